// File: rtl/narvie_pkg.sv
// Shared definitions for the instruction-injection controller.
//   state_t      : controller FSM states
//   NopInstr     : canonical RV32I NOP (addi x0, x0, 0)
//   OpStore/OpBranch/OpFence : opcodes whose injection yields no destination register
//   writes_rd()  : classifies whether an instruction produces a register result
package narvie_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StRead,
        StResp
    } state_t;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpFence  = 7'b0001111;

    // Stores, branches and fences have no rd; rd==x0 discards the result anyway.
    function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
        logic no_rd;
        no_rd = (opcode == OpStore) || (opcode == OpBranch) || (opcode == OpFence) ||
                (rd == 5'd0);
        return !no_rd;
    endfunction

endpackage

// File: rtl/instr_inject_ctrl.sv
// Injects single host instructions into a CPU by overriding its instruction-memory
// read data, pads with NOPs until the instruction has retired, then reads the
// destination register back through the register-file debug port.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/ready      : host command handshake, cmd_instr is the instruction word
//   cpu_instr            : instruction word presented to the CPU
//   dbg_rd_addr/data     : register-file debug read port (data is combinational)
//   rsp_valid/ready      : response handshake, rsp_data/rsp_has_rd is the result
//   busy                 : high whenever a command is in flight
//
// DRAIN_CYCLES must lie in 1..15 (it is loaded into a 4-bit counter).
module instr_inject_ctrl
    import narvie_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR    = NopInstr,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_instr,
    output logic [31:0] cpu_instr,
    output logic [4:0]  dbg_rd_addr,
    input  logic [31:0] dbg_rd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_has_rd,
    output logic        busy
);

    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    // Only the rd field and its classification are needed after the issue cycle.
    logic [4:0] cap_rd;
    logic       cap_has_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            drain_cnt  <= 4'd0;
            cap_rd     <= NOP_INSTR[11:7];
            cap_has_rd <= writes_rd(NOP_INSTR[6:0], NOP_INSTR[11:7]);
            cpu_instr  <= NOP_INSTR;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'h0;
            rsp_has_rd <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cap_rd     <= cmd_instr[11:7];
                        cap_has_rd <= writes_rd(cmd_instr[6:0], cmd_instr[11:7]);
                        // Registered here so the word is on cpu_instr for the ISSUE cycle.
                        cpu_instr  <= cmd_instr;
                        state      <= StIssue;
                    end
                end
                StIssue: begin
                    cpu_instr <= NOP_INSTR;
                    drain_cnt <= DrainLoad;
                    state     <= StDrain;
                end
                StDrain: begin
                    // NOPs flush the pipeline and absorb any PC redirect.
                    if (drain_cnt == 4'd0) begin
                        state <= StRead;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                StRead: begin
                    rsp_valid  <= 1'b1;
                    rsp_has_rd <= cap_has_rd;
                    rsp_data   <= cap_has_rd ? dbg_rd_data : 32'h0;
                    state      <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready   = (state == StIdle);
    assign busy        = (state != StIdle);
    assign dbg_rd_addr = (state == StRead) ? cap_rd : 5'd0;

endmodule
